// File: rtl/melody_sequencer.sv
// melody_sequencer: RAM-programmed tone sequencer (LOAD/PLAY/GAP) driving a frequency word.
// Optional MELODY_LOOP_EN: `loop` wraps playback to step 0 instead of finishing.
module melody_sequencer #(
    parameter int STEPS     = 16,
    parameter int NOTE_W    = 16,
    parameter int DUR_W     = 4,
    parameter int TICK_DIV  = 4,
    parameter int GAP_TICKS = 1,
    localparam int SW = $clog2(STEPS)
) (
    input  logic              sound_clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [SW-1:0]     wr_addr,
    input  logic [4:0]        wr_pitch,
    input  logic [DUR_W-1:0]  wr_dur,
    input  logic [SW:0]       length,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic [NOTE_W-1:0] sound,
    output logic              sound_on,
    output logic              busy,
    output logic              done,
    output logic [SW-1:0]     step
);
    localparam int GW = $clog2(GAP_TICKS + 1);
    localparam int CW = (DUR_W > GW ? DUR_W : GW) + 1;
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;
    state_t state, nxt;

    logic [4+DUR_W:0] ram [STEPS];
    logic [SW:0]      len, len_n;
    logic [SW-1:0]    step_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [PW-1:0]    presc, presc_n;
    logic [4:0]       pitch, pitch_n;
    logic             done_n, tick, last_tick, last_step, note_end, wrap;

    function automatic logic [NOTE_W-1:0] pitch_word(input logic [4:0] p);
        logic [10:0] f;
        case (p)
            5'd1:    f = 11'd400;
            5'd2:    f = 11'd423;
            5'd3:    f = 11'd448;
            5'd4:    f = 11'd475;
            5'd5:    f = 11'd503;
            5'd6:    f = 11'd533;
            5'd7:    f = 11'd565;
            5'd8:    f = 11'd599;
            5'd9:    f = 11'd634;
            5'd10:   f = 11'd672;
            5'd11:   f = 11'd712;
            5'd12:   f = 11'd755;
            5'd13:   f = 11'd800;
            5'd14:   f = 11'd847;
            5'd15:   f = 11'd897;
            5'd16:   f = 11'd951;
            5'd17:   f = 11'd1007;
            5'd18:   f = 11'd1067;
            5'd19:   f = 11'd1131;
            5'd20:   f = 11'd1198;
            default: f = 11'd1;
        endcase
        return NOTE_W'(f);
    endfunction

`ifdef MELODY_LOOP_EN
    assign wrap = loop;
`else
    logic unused_loop;
    assign unused_loop = loop;
    assign wrap = 1'b0;
`endif

    // Writes land at the clock edge, so a LOAD of the same address in that cycle still sees old data.
    always_ff @(posedge sound_clock)
        if (wr_en && {1'b0, wr_addr} < (SW+1)'(STEPS)) ram[wr_addr] <= {wr_pitch, wr_dur};

    assign tick      = presc == PW'(TICK_DIV - 1);
    assign last_tick = tick && cnt == CW'(1);
    assign last_step = {1'b0, step} == len - (SW+1)'(1);
    assign note_end  = state == GAP ? last_tick : state == PLAY && GAP_TICKS == 0 && last_tick;

    always_comb begin
        nxt     = state;
        step_n  = step;
        len_n   = len;
        cnt_n   = cnt;
        pitch_n = pitch;
        done_n  = 1'b0;
        case (state)
            IDLE: if (start && length != '0) begin
                nxt    = LOAD;
                step_n = '0;
                len_n  = length > (SW+1)'(STEPS) ? (SW+1)'(STEPS) : length;
            end
            LOAD: begin
                nxt     = PLAY;
                pitch_n = ram[step][4+DUR_W:DUR_W];
                cnt_n   = CW'(ram[step][DUR_W-1:0]) + CW'(1);
            end
            PLAY: if (tick) begin
                cnt_n = last_tick ? CW'(GAP_TICKS) : cnt - CW'(1);
                if (last_tick && GAP_TICKS != 0) nxt = GAP;
            end
            default: if (tick) cnt_n = cnt - CW'(1);
        endcase
        if (note_end) begin
            done_n = last_step && !wrap;
            nxt    = done_n ? IDLE : LOAD;
            step_n = done_n ? step : last_step ? '0 : step + SW'(1);
        end
        if (stop) begin
            nxt    = IDLE;
            step_n = step;
            len_n  = len;
            done_n = 1'b0;
        end
        // Prescaler only runs inside PLAY/GAP so every phase is a whole number of ticks.
        presc_n = (state == PLAY || state == GAP) && !tick && nxt != IDLE ? presc + PW'(1) : '0;
    end

    always_ff @(posedge sound_clock or posedge reset)
        if (reset) begin
            state    <= IDLE;
            step     <= '0;
            len      <= '0;
            cnt      <= '0;
            presc    <= '0;
            pitch    <= '0;
            sound    <= NOTE_W'(1);
            sound_on <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= nxt;
            step     <= step_n;
            len      <= len_n;
            cnt      <= cnt_n;
            presc    <= presc_n;
            pitch    <= pitch_n;
            sound    <= nxt == PLAY ? pitch_word(pitch_n) : NOTE_W'(1);
            sound_on <= nxt == PLAY && pitch_n inside {[5'd1:5'd20]};
            busy     <= nxt != IDLE;
            done     <= done_n;
        end
endmodule
